// File: rtl/uart_rx_deserializer.sv
// UART receiver: 2-flop sync, 16x oversampled start detect, LSB-first shift, parity/stop check.
// Byte is written 1 Clk after the stop-bit centre; FULL at that instant drops the byte as an overrun.
module uart_rx_deserializer #(
  parameter int BAUD_DIV   = 27,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       EN,
  input  logic       RxD,
  input  logic       FULL,
  output logic [7:0] dataOut,
  output logic       WR,
  output logic       BUSY,
  output logic       FERR,
  output logic       PERR,
  output logic       OVERRUN
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_TC  = CW'(BAUD_DIV - 1);
  localparam logic [2:0]    LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_m_q, rx_m_d;
  logic                   rx_s_q, rx_s_d;
  logic                   rx_d_q, rx_d_d;
  logic [2:0]             settle_q, settle_d;
  logic [CW-1:0]          baud_cnt_q, baud_cnt_d;
  logic [3:0]             os_cnt_q, os_cnt_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_latch_q, perr_latch_d;
  logic [7:0]             data_out_q, data_out_d;
  logic                   wr_q, wr_d;
  logic                   busy_q, busy_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   ovr_q, ovr_d;

  logic tick, sample, fall;

  always_comb begin
    rx_m_d       = RxD;
    rx_s_d       = rx_m_q;
    rx_d_d       = rx_s_q;
    settle_d     = {settle_q[1:0], 1'b1};
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    perr_latch_d = perr_latch_q;
    data_out_d   = data_out_q;
    wr_d         = 1'b0;
    ferr_d       = 1'b0;
    perr_d       = 1'b0;
    ovr_d        = 1'b0;

    tick       = (baud_cnt_q == BAUD_TC);
    baud_cnt_d = tick ? '0 : baud_cnt_q + 1'b1;
    os_cnt_d   = tick ? os_cnt_q + 4'd1 : os_cnt_q;
    sample     = tick && (os_cnt_q == 4'd7);
    // The synchroniser powers up at 1, so edges are ignored until it holds real line samples.
    fall       = settle_q[2] && rx_d_q && !rx_s_q;

    if (!EN) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (fall) begin
          state_d    = START;
          baud_cnt_d = '0;
          os_cnt_d   = 4'd0;
        end
        START: if (sample) begin
          if (!rx_s_q) begin
            state_d      = DATA;
            bit_cnt_d    = 3'd0;
            perr_latch_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        DATA: if (sample) begin
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
        end
        PARITY: if (sample) begin
          perr_latch_d = rx_s_q ^ (^shift_q) ^ ODD;
          state_d      = STOP;
        end
        STOP: if (sample) begin
          // Leave half a bit early so a back-to-back start edge is not missed.
          state_d = IDLE;
          if (!rx_s_q)          ferr_d = 1'b1;
          else if (perr_latch_q) perr_d = 1'b1;
          else if (FULL)         ovr_d  = 1'b1;
          else begin
            wr_d       = 1'b1;
            data_out_d = 8'(shift_q);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q      <= IDLE;
      rx_m_q       <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      settle_q     <= 3'b000;
      baud_cnt_q   <= '0;
      os_cnt_q     <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= '0;
      perr_latch_q <= 1'b0;
      data_out_q   <= 8'h00;
      wr_q         <= 1'b0;
      busy_q       <= 1'b0;
      ferr_q       <= 1'b0;
      perr_q       <= 1'b0;
      ovr_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_m_q       <= rx_m_d;
      rx_s_q       <= rx_s_d;
      rx_d_q       <= rx_d_d;
      settle_q     <= settle_d;
      baud_cnt_q   <= baud_cnt_d;
      os_cnt_q     <= os_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      perr_latch_q <= perr_latch_d;
      data_out_q   <= data_out_d;
      wr_q         <= wr_d;
      busy_q       <= busy_d;
      ferr_q       <= ferr_d;
      perr_q       <= perr_d;
      ovr_q        <= ovr_d;
    end
  end

  assign dataOut = data_out_q;
  assign WR      = wr_q;
  assign BUSY    = busy_q;
  assign FERR    = ferr_q;
  assign PERR    = perr_q;
  assign OVERRUN = ovr_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Directed bench: two receivers (no parity / even parity) at 64 Clk per bit.
module tb_uart_rx_deserializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       rxd = 1'b1;
  logic       rxd_p = 1'b1;
  logic       full = 1'b0;
  logic [7:0] data_out, data_out_p;
  logic       wr, busy, ferr, perr, ovr;
  logic       wr_p, busy_p, ferr_p, perr_p, ovr_p;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int wr_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0, long_cnt = 0;
  int wr_cnt_p = 0, perr_cnt_p = 0;
  int wr_cyc = 0;
  logic [7:0] got_q[$];
  logic [7:0] got_p_q[$];
  logic prev_wr = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

  localparam int BIT = 64;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_rx_deserializer #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .Clk(clk), .Rst_n(rst_n), .EN(en), .RxD(rxd), .FULL(full),
    .dataOut(data_out), .WR(wr), .BUSY(busy), .FERR(ferr), .PERR(perr), .OVERRUN(ovr));

  uart_rx_deserializer #(.BAUD_DIV(4), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .Clk(clk), .Rst_n(rst_n), .EN(en), .RxD(rxd_p), .FULL(full),
    .dataOut(data_out_p), .WR(wr_p), .BUSY(busy_p), .FERR(ferr_p), .PERR(perr_p), .OVERRUN(ovr_p));

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin wr_cnt++; wr_cyc = cyc; got_q.push_back(data_out); end
      if (ferr) ferr_cnt++;
      if (perr) perr_cnt++;
      if (ovr) ovr_cnt++;
      if ((wr && prev_wr) || (ferr && prev_ferr) || (ovr && prev_ovr)) long_cnt++;
      if (wr_p) begin wr_cnt_p++; got_p_q.push_back(data_out_p); end
      if (perr_p) perr_cnt_p++;
      prev_wr = wr; prev_ferr = ferr; prev_ovr = ovr;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rxd_p = v; else rxd = v;
  endtask

  task automatic bit_time(input bit sel, input logic v);
    drive(sel, v);
    repeat (BIT) @(negedge clk);
  endtask

  // Frame: start, 8 data LSB-first, optional parity, stop.
  task automatic send_frame(input bit sel, input logic [7:0] b, input logic stop_v,
                            input bit use_par, input logic par_v);
    bit_time(sel, 1'b0);
    for (int i = 0; i < 8; i++) bit_time(sel, b[i]);
    if (use_par) bit_time(sel, par_v);
    bit_time(sel, stop_v);
    drive(sel, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int base_wr, base_ferr, base_perr, base_ovr, t0, lat, base_q;

  initial begin
    idle(3);
    chk("reset_dataOut", 32'(data_out), 32'h00);
    chk("reset_flags", 32'({wr, busy, ferr, perr, ovr}), 32'h0);
    rst_n = 1'b1;
    idle(10);

    // 1: single frame 0xA5, latency from line edge to WR
    base_wr = wr_cnt; base_ferr = ferr_cnt;
    t0 = cyc;
    send_frame(1'b0, 8'hA5, 1'b1, 1'b0, 1'b0);
    idle(40);
    lat = wr_cyc - t0;
    chk("t1_wr_count", 32'(wr_cnt - base_wr), 32'd1);
    chk("t1_data", 32'(got_q[got_q.size()-1]), 32'hA5);
    chk("t1_latency_window", 32'((lat >= 608) && (lat <= 612)), 32'd1);
    chk("t1_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);

    // 2: back-to-back frames
    base_q = got_q.size();
    send_frame(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    send_frame(1'b0, 8'h3C, 1'b1, 1'b0, 1'b0);
    idle(40);
    chk("t2_count", 32'(got_q.size() - base_q), 32'd3);
    if (got_q.size() >= base_q + 3) begin
      chk("t2_byte0", 32'(got_q[base_q]), 32'h00);
      chk("t2_byte1", 32'(got_q[base_q+1]), 32'hFF);
      chk("t2_byte2", 32'(got_q[base_q+2]), 32'h3C);
    end
    chk("t2_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);

    // 3: 20-cycle glitch is rejected
    base_wr = wr_cnt;
    rxd = 1'b0; idle(20); rxd = 1'b1; idle(5);
    chk("t3_busy_in_start", 32'(busy), 32'd1);
    idle(40);
    chk("t3_busy_cleared", 32'(busy), 32'd0);
    chk("t3_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    chk("t3_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
    send_frame(1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    idle(40);
    chk("t3_data55", 32'(got_q[got_q.size()-1]), 32'h55);
    chk("t3_one_wr", 32'(wr_cnt - base_wr), 32'd1);

    // 4: framing error, then parity error / good parity on the parity receiver
    base_wr = wr_cnt; base_ferr = ferr_cnt;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    idle(40);
    chk("t4_ferr", 32'(ferr_cnt - base_ferr), 32'd1);
    chk("t4_ferr_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    chk("t4_dataOut_held", 32'(data_out), 32'h55);
    base_perr = perr_cnt_p;
    send_frame(1'b1, 8'h81, 1'b1, 1'b1, 1'b1);
    idle(40);
    chk("t4_perr", 32'(perr_cnt_p - base_perr), 32'd1);
    chk("t4_perr_no_wr", 32'(wr_cnt_p), 32'd0);
    send_frame(1'b1, 8'h81, 1'b1, 1'b1, 1'b0);
    idle(40);
    chk("t4_par_ok_wr", 32'(wr_cnt_p), 32'd1);
    chk("t4_par_ok_data", 32'(data_out_p), 32'h81);

    // 5: overrun while FIFO full
    base_wr = wr_cnt; base_ovr = ovr_cnt;
    full = 1'b1;
    send_frame(1'b0, 8'h7E, 1'b1, 1'b0, 1'b0);
    idle(40);
    full = 1'b0;
    chk("t5_overrun", 32'(ovr_cnt - base_ovr), 32'd1);
    chk("t5_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    chk("t5_dataOut_kept", 32'(data_out), 32'h55);

    // 6a: async reset in the middle of data bit 4
    base_wr = wr_cnt;
    fork
      send_frame(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
      begin
        idle(5*BIT + 32);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        idle(3);
        rst_n = 1'b1;
      end
    join
    idle(40);
    chk("t6_rst_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    chk("t6_rst_dataOut", 32'(data_out), 32'h00);
    send_frame(1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
    idle(40);
    chk("t6_rst_next", 32'(got_q[got_q.size()-1]), 32'h12);
    chk("t6_rst_next_wr", 32'(wr_cnt - base_wr), 32'd1);

    // 6b: EN dropped in the middle of data bit 4
    base_wr = wr_cnt; base_ferr = ferr_cnt;
    fork
      send_frame(1'b0, 8'hC3, 1'b1, 1'b0, 1'b0);
      begin
        idle(5*BIT + 32);
        en = 1'b0;
        idle(1);
        chk("t6_en_busy", 32'(busy), 32'd0);
        idle(10);
        en = 1'b1;
      end
    join
    idle(40);
    chk("t6_en_no_wr", 32'(wr_cnt - base_wr), 32'd0);
    chk("t6_en_no_ferr", 32'(ferr_cnt - base_ferr), 32'd0);
    send_frame(1'b0, 8'h12, 1'b1, 1'b0, 1'b0);
    idle(40);
    chk("t6_en_next", 32'(got_q[got_q.size()-1]), 32'h12);
    chk("t6_en_next_wr", 32'(wr_cnt - base_wr), 32'd1);

    chk("pulse_width_one_clk", 32'(long_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
